// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// op encodings (funct3), FSM state type and small op-decoding helpers.
package muldiv_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_MUL    = 3'b000;
  localparam op_t OP_MULH   = 3'b001;
  localparam op_t OP_MULHSU = 3'b010;
  localparam op_t OP_MULHU  = 3'b011;
  localparam op_t OP_DIV    = 3'b100;
  localparam op_t OP_DIVU   = 3'b101;
  localparam op_t OP_REM    = 3'b110;
  localparam op_t OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } state_e;

  // Divide family (DIV/DIVU/REM/REMU) is the upper half of the encoding.
  function automatic logic is_div(input op_t op);
    return op[2];
  endfunction

  // REM/REMU return the remainder instead of the quotient.
  function automatic logic is_rem(input op_t op);
    return op[2] & op[1];
  endfunction

  // rs1 is treated as two's complement for these ops.
  function automatic logic is_signed_a(input op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement for these ops.
  function automatic logic is_signed_b(input op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration shared by multiply and divide.
// Multiply: shift-add; {acc, lo} is the product register, lo[0] is the
//   current multiplier bit, b_i the multiplicand magnitude.
// Divide: restoring step; acc is the partial remainder, lo shifts the
//   dividend out at the top and the quotient bits in at the bottom.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Both step flavours are evaluated; is_div picks which one is retired.
  always_comb begin
    // Multiply: conditional add with carry kept, then shift the 2*XLEN register right.
    sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    // Divide: XLEN+1 bit partial remainder after shifting in the next dividend bit.
    shifted = {acc_i, lo_i[XLEN-1]};
    ge      = (shifted >= {1'b0, b_i});
    // When ge holds the difference is below the divisor, so XLEN bits suffice.
    diff    = shifted[XLEN-1:0] - b_i;
    if (is_div) begin
      acc_o = ge ? diff : shifted[XLEN-1:0];
      lo_o  = {lo_i[XLEN-2:0], ge};
    end else begin
      acc_o = sum[XLEN:1];
      lo_o  = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// at accept, iterated UNROLL bits per cycle through a chain of muldiv_step,
// then sign-corrected and selected in FIXUP. Divide-by-zero and signed
// overflow are resolved at accept and skip straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN   = 32,  // power of two, >= 8
  parameter int UNROLL = 1    // 1, 2 or 4; must divide XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int ITER  = XLEN / UNROLL;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER - 1);
  localparam logic [XLEN-1:0]  MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  // Control state (reset)
  state_e          state_q,  state_d;
  logic            ready_q,  ready_d;
  logic            busy_q,   busy_d;
  logic            valid_q,  valid_d;
  logic [XLEN-1:0] result_q, result_d;

  // Datapath state (no reset)
  op_t             op_q,  op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] lo_q,  lo_d;
  logic [XLEN-1:0] b_q,   b_d;
  logic            neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept-side decode and fixup-side results
  logic            sign_a, sign_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic [2*XLEN-1:0] product, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  // Step chain: UNROLL radix-2 iterations per CALC cycle
  logic [XLEN-1:0] acc_chain [UNROLL+1];
  logic [XLEN-1:0] lo_chain  [UNROLL+1];

  assign acc_chain[0] = acc_q;
  assign lo_chain[0]  = lo_q;

  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div (is_div(op_q)),
      .acc_i  (acc_chain[i]),
      .lo_i   (lo_chain[i]),
      .b_i    (b_q),
      .acc_o  (acc_chain[i+1]),
      .lo_o   (lo_chain[i+1])
    );
  end

  // Operand signs/magnitudes and early-out divide results, from the live inputs.
  always_comb begin
    sign_a = is_signed_a(op) & a[XLEN-1];
    sign_b = is_signed_b(op) & b[XLEN-1];
    mag_a  = sign_a ? (~a + 1'b1) : a;
    mag_b  = sign_b ? (~b + 1'b1) : b;
    special     = 1'b0;
    special_res = '0;
    if (is_div(op)) begin
      if (b == '0) begin
        special     = 1'b1;
        special_res = is_rem(op) ? a : '1;
      end else if (is_signed_a(op) && (a == MIN_INT) && (b == '1)) begin
        special     = 1'b1;
        special_res = is_rem(op) ? '0 : a;
      end
    end
  end

  // Sign correction and result selection from the finished iteration registers.
  always_comb begin
    product  = {acc_q, lo_q};
    prod_fix = neg_q ? (~product + 1'b1) : product;
    quot_fix = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    case (op_q)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quot_fix;
      OP_REM, OP_REMU:               fix_res = rem_fix;
      default:                       fix_res = '0;
    endcase
  end

  // Next-state logic for the FSM, iteration registers and result.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    result_d = result_q;
    op_d     = op_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op;
          acc_d = '0;
          lo_d  = mag_a;
          b_d   = mag_b;
          // Remainder follows the dividend; product and quotient follow sign(a)^sign(b).
          neg_d = is_rem(op) ? sign_a : (sign_a ^ sign_b);
          cnt_d = CNT_INIT;
          if (special) begin
            result_d = special_res;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_chain[UNROLL];
        lo_d  = lo_chain[UNROLL];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = ST_FIXUP;
      end
      ST_FIXUP: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over everything, including a same-cycle accept; result is kept.
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
    end

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_CALC) || (state_d == ST_FIXUP);
    valid_d = (state_d == ST_DONE);
  end

  // Control registers with synchronous reset; outputs are registered state decodes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  // Iteration datapath registers; always loaded at accept before being read.
  // NOTE: these have no reset on purpose -- their contents are don't-care until an accept overwrites them.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    acc_q <= acc_d;
    lo_q  <= lo_d;
    b_q   <= b_d;
    neg_q <= neg_d;
    cnt_q <= cnt_d;
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit implementing the RV32M operations. It is the multi-cycle companion to the single-cycle integer ALU.
- Sits beside the ALU in the execute stage. The controller holds the pipeline while `busy` is high and captures `result` when `valid` pulses.
- Parametrised in datapath width and in bits retired per cycle.

Parameters:
- XLEN, 32, operand/result width; must be a power of two, 8 or more.
- UNROLL, 1, bits processed per iteration cycle; allowed values 1, 2, 4; must divide XLEN.
- ITER, XLEN/UNROLL, derived localparam; number of CALC cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when `ready`=1 and `flush`=0
- op  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- flush  in  1  abort any operation in flight
- ready  out  1  high in IDLE only
- busy  out  1  high in CALC and FIXUP
- valid  out  1  one-cycle pulse; `result` is valid in that cycle
- result  out  XLEN  last completed result; held until the next completion
- zero  out  1  equals (`result` == 0)

Behaviour:
- Interface is decided: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: state IDLE, `ready`=1, `busy`=0, `valid`=0, `result`=0, `zero`=1. Reset asserted mid-operation discards all work at the next edge.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, on accept:
  - Latch `op`, `a`, `b`, and operand sign flags.
  - Load iteration counter with ITER-1.
  - Go to CALC.
  - Special divide cases go directly to DONE instead (see below).
- CALC:
  - Multiply: shift-add on operand magnitudes, UNROLL multiplier bits per cycle, into a 2*XLEN product register.
  - Divide: restoring division on magnitudes, UNROLL quotient bits per cycle, with an XLEN+1 bit partial remainder.
  - When counter = 0, go to FIXUP.
- FIXUP:
  - Apply sign correction (two's-complement negate where needed).
  - Select: MUL takes product[XLEN-1:0]; MULH/MULHSU/MULHU take product[2*XLEN-1:XLEN]; DIV/DIVU take the quotient; REM/REMU take the remainder.
  - Write `result`, go to DONE.
- DONE: `valid`=1 for exactly this cycle. `ready`=0. Go to IDLE.
- Latency: accept at edge N gives `valid` high during cycle N+ITER+2. Default ITER=32, so 34 cycles.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: `a` signed, `b` unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend.
- Special cases: detected in IDLE at accept, written to `result` at accept, then DONE. `valid` is high in cycle N+1.
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give `a`.
  - Signed overflow, `a`=100…0 with `b`=all-ones: DIV gives `a`; REM gives 0.
- `start` while not `ready` is ignored; no queueing. Operand and `op` changes after accept have no effect.
- `flush`:
  - Forces IDLE at the next edge from any state. No `valid` pulse; `result` keeps its previous value.
  - `flush` and `start` in the same cycle: flush wins, nothing is accepted.
  - `flush` during DONE: the `valid` pulse in that cycle still occurs.
- `zero` is derived combinationally from the `result` register.

Decomposition:
- Package muldiv_pkg holds:
  - the op encoding localparams (OP_MUL … OP_REMU);
  - the state enum typedef;
  - helpers is_div(op) and is_signed_a/b(op).
- Sub-module muldiv_step is combinational, one radix-2 iteration for both mul and div. The top instantiates it UNROLL times in a chain.
- Top-level holds the FSM, counter, registers, and fixup logic.

Test Plan:
- MUL a=0x0000_0007, b=0xFFFF_FFFD (-3) → `result`=0xFFFF_FFEB, `valid` exactly 34 cycles after accept, `busy` high for 33 of those cycles.
- MULH a=0x8000_0000, b=0x8000_0000 → 0x4000_0000. MULHU of the same operands → 0x4000_0000. MULHSU a=0xFFFF_FFFF, b=0xFFFF_FFFF → 0xFFFF_FFFF.
- DIV a=-7 (0xFFFF_FFF9), b=2 → 0xFFFF_FFFD (-3). REM of the same → 0xFFFF_FFFF (-1). DIVU a=100, b=7 → 14. REMU of the same → 2.
- DIVU a=5, b=0 → 0xFFFF_FFFF with `valid` at N+1. REM a=5, b=0 → 5. DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000. REM of the same → 0 with `zero`=1.
- Accept DIV, assert `flush` at cycle N+10 → IDLE at N+11, no `valid`, `result` unchanged. `start` pulsed during CALC is ignored. `reset` mid-CALC → `result`=0 and `ready`=1 next cycle.
- Rerun all vectors with UNROLL=4 → identical results, latency ITER+2=10. Random a/b/op for 10k operations against a reference model, with back-to-back `start` asserted the cycle after `valid`.
